// File: rtl/tick_scheduler.sv
// Programmable multi-channel tick-enable and divided-clock generator.
// Each channel is configured through a two-state valid/ready port and counts in the CLK domain.
module tick_scheduler #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 24,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_mode,
    input  logic              sync_pulse,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] active
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic               ready_reg;
    logic [CH_W-1:0]    hold_ch_reg;
    logic [DIV_W-1:0]   hold_div_reg;
    logic [1:0]         hold_mode_reg;
    logic               accept;
    logic               apply_en;

    assign accept    = cfg_valid && ready_reg && (state_reg == ST_IDLE);
    assign apply_en  = (state_reg == ST_APPLY);
    assign cfg_ready = ready_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_APPLY;
            ST_APPLY: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ready is registered so it only rises one edge after reset is released
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            ready_reg     <= 1'b0;
            hold_ch_reg   <= '0;
            hold_div_reg  <= DIV_W'(1);
            hold_mode_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == ST_IDLE);
            if (accept) begin
                hold_ch_reg   <= cfg_ch;
                hold_div_reg  <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
                hold_mode_reg <= cfg_mode;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] cnt_reg;
            logic [DIV_W-1:0] div_reg;
            logic             run_reg;
            logic             oneshot_reg;
            logic             tick_reg;
            logic             clk_reg;
            logic             hit;
            logic             wrap;

            // an out-of-range channel index matches no channel, so APPLY writes nothing
            assign hit  = apply_en && (hold_ch_reg == CH_W'(gi));
            assign wrap = (cnt_reg == (div_reg - DIV_W'(1)));

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    cnt_reg     <= '0;
                    div_reg     <= DIV_W'(1);
                    run_reg     <= 1'b0;
                    oneshot_reg <= 1'b0;
                    tick_reg    <= 1'b0;
                    clk_reg     <= 1'b0;
                end else if (hit) begin
                    div_reg     <= hold_div_reg;
                    run_reg     <= (hold_mode_reg == 2'b01) || (hold_mode_reg == 2'b10);
                    oneshot_reg <= (hold_mode_reg == 2'b10);
                    cnt_reg     <= '0;
                    tick_reg    <= 1'b0;
                    clk_reg     <= 1'b0;
                end else if (sync_pulse) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b0;
                    clk_reg  <= 1'b0;
                end else if (run_reg) begin
                    tick_reg <= wrap;
                    if (wrap) begin
                        cnt_reg <= '0;
                        clk_reg <= ~clk_reg;
                        // a fired one-shot stops but keeps clk_out at its toggled level
                        if (oneshot_reg) begin
                            run_reg     <= 1'b0;
                            oneshot_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end else begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b0;
                end
            end

            assign tick[gi]    = tick_reg;
            assign clk_out[gi] = clk_reg;
            assign active[gi]  = run_reg;
        end
    endgenerate

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Programmable multi-channel clock-enable and divided-clock generator.
- Replaces fixed-ratio dividing for game-logic timing.
- Game/control logic configures each channel's period and mode over a valid/ready port.
- The block produces single-cycle tick enables and 50%-duty divided square waves, all in the CLK domain.

Parameters:
NUM_CH, 4, number of independent channels
DIV_W, 24, width of period value and per-channel counter

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
cfg_valid  in  1  configuration request
cfg_ready  out  1  block can accept configuration
cfg_ch  in  clog2(NUM_CH)  target channel index
cfg_div  in  DIV_W  period N in CLK cycles; 0 treated as 1
cfg_mode  in  2  00 stop, 01 periodic, 10 one-shot, 11 reserved (= stop)
sync_pulse  in  1  global phase realign; clears all running counters
tick  out  NUM_CH  one-cycle enable per channel
clk_out  out  NUM_CH  divided clock, toggles on each tick (period 2N)
active  out  NUM_CH  channel running (periodic, or one-shot not yet fired)

Behaviour:
- Reset (RESET high at an edge): FSM=IDLE, all modes=stop, div=1, counters=0, tick=0, clk_out=0, active=0, cfg_ready=0.
  - cfg_ready rises the cycle after the first edge with RESET low.
  - Reset mid-operation aborts any pending APPLY; the captured config is discarded.
- Config FSM, two states:
  - IDLE: cfg_ready=1. On an edge with cfg_valid&&cfg_ready (accept edge E0), capture cfg_ch/cfg_div/cfg_mode into holding regs, go to APPLY.
  - APPLY: cfg_ready=0. At the next edge E1, write the held values into the channel, force its counter=0, tick=0, clk_out=0, go to IDLE.
  - Maximum throughput: one config per 2 cycles.
  - cfg_valid while cfg_ready=0 is ignored; the requester must hold it.
- Channel counting, per channel i with effective period N = max(cfg_div, 1):
  - While active: counter increments each edge. At an edge where counter==N-1: counter wraps to 0, tick[i] registered high for exactly the following cycle, clk_out[i] toggles.
  - Otherwise tick[i]=0.
  - First tick is visible in the cycle after edge E1+N. Subsequent ticks every N cycles.
  - N=1: tick continuously high from the cycle after E1+1; clk_out toggles every cycle.
- Modes:
  - Periodic runs until reconfigured.
  - One-shot: on its first tick edge, mode becomes stop and active drops in the same cycle the tick is high. clk_out stays at its toggled value (1).
  - Stop: counter held 0, tick 0, clk_out forced 0.
- Reconfiguring a running channel restarts it from counter 0 at E1; no partial or extra tick is generated.
- sync_pulse at an edge: all counters=0, all clk_out=0, no tick for that edge. Modes are unchanged.
- sync_pulse coincident with E1: the APPLY write to the target channel takes effect (same result as the sync); other channels are cleared by the sync.
- Counter width DIV_W; cfg_div up to 2^DIV_W-1 supported with no overflow. Counter never exceeds N-1.
- cfg_ch ≥ NUM_CH: accepted; APPLY performs no write.

Test Plan:
- Reset then idle: RESET high 3 cycles then low -> all outputs 0, cfg_ready=1 from the 2nd cycle after release, and no ticks for 50 cycles.
- Periodic ch0, div=5, single accept -> cfg_ready=0 for exactly 1 cycle; first tick[0] 5 cycles after E1, then every 5 cycles; clk_out[0] period 10; tick one cycle wide.
- One-shot ch2, div=3 -> exactly one tick[2] 3 cycles after E1; active[2] 1→0 in the same cycle; no further ticks in 30 cycles; clk_out[2] stays 1.
- ch1 periodic div=4 running; at counter==2 reconfigure to div=2 -> no tick at the old position; ticks at E1+2, +4, …; div=0 behaves identically to div=1.
- ch0 div=3 and ch1 div=7 running; assert sync_pulse one cycle -> both counters and clk_outs cleared, no tick at that edge; next ticks at +3 and +7 edges.
- Back-to-back cfg_valid held high for 4 configs -> accepts every other cycle; RESET asserted during APPLY -> target channel stays stopped.
